alarm_tone_gen: RTL and testbench

// Alarm buzzer driver fed by the 8-bit control PIO output port. Generates a square-wave tone with a

---
 rtl/alarm_tone_gen.sv | 134 +++++++++++++
 tb/tb_alarm_tone_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_tone_gen.sv
// Alarm buzzer driver: square-wave tone with selectable pitch and cadence.
// Local silence button mutes the alarm until software drops the enable bit.
module alarm_tone_gen #(
  parameter int unsigned TONE_BASE   = 25000,
  parameter int unsigned TONE_STEP   = 500,
  parameter int unsigned BEAT_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ctrl,
  input  logic       silence_n,
  output logic       buzzer,
  output logic       ringing,
  output logic       beat
);

  localparam int BW =
    (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BW-1:0] BEAT_LAST =
    BW'(BEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RING     = 2'd1,
    SILENCED = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   tone_cnt;
  logic [31:0]   tone_last;
  logic [BW-1:0] beat_cnt;
  logic [2:0]    beat_idx;
  logic [1:0]    mode;
  logic          phase;

  logic          en;
  logic          tone_wrap;
  logic          beat_wrap;
  logic          gate;

  assign en        = ctrl[0];
  assign tone_wrap = (tone_cnt == tone_last);
  assign beat_wrap = (beat_cnt == BEAT_LAST);

  // Half-period minus one for a tone index, kept at 32 bits.
  function automatic logic [31:0] half_last(
    input logic [4:0] t
  );
    logic [31:0] h;
    h = 32'(TONE_BASE) + 32'(t) * 32'(TONE_STEP);
    return h - 32'd1;
  endfunction

  // Cadence gate from the latched mode and current beat index.
  always_comb begin
    gate = 1'b0;
    unique case (mode)
      2'd0: gate = 1'b1;
      2'd1: gate = ~beat_idx[0];
      2'd2: gate = ~beat_idx[0] && (beat_idx <= 3'd4);
      2'd3: gate = ~beat_idx[2];
      default: gate = 1'b0;
    endcase
  end

  // State machine, tone/cadence counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      tone_cnt  <= '0;
      tone_last <= '0;
      beat_cnt  <= '0;
      beat_idx  <= '0;
      mode      <= '0;
      phase     <= 1'b0;
      buzzer    <= 1'b0;
      ringing   <= 1'b0;
      beat      <= 1'b0;
    end else begin
      beat   <= 1'b0;
      buzzer <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && silence_n) begin
            state     <= RING;
            ringing   <= 1'b1;
            tone_cnt  <= '0;
            tone_last <= half_last(ctrl[7:3]);
            beat_cnt  <= '0;
            beat_idx  <= '0;
            mode      <= ctrl[2:1];
            phase     <= 1'b1;
          end
        end
        RING: begin
          if (!en) begin
            state   <= IDLE;
            ringing <= 1'b0;
          end else if (!silence_n) begin
            state   <= SILENCED;
            ringing <= 1'b0;
          end else begin
            buzzer <= phase & gate;
            if (tone_wrap) begin
              tone_cnt  <= '0;
              phase     <= ~phase;
              tone_last <= half_last(ctrl[7:3]);
            end else begin
              tone_cnt <= tone_cnt + 32'd1;
            end
            if (beat_wrap) begin
              beat_cnt <= '0;
              beat     <= 1'b1;
              beat_idx <= beat_idx + 3'd1;
              mode     <= ctrl[2:1];
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        SILENCED: begin
          if (!en) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ringing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Bench for alarm_tone_gen: cycle model of the alarm plus
// directed vectors with hand-computed expectations.
module tb_alarm_tone_gen;

  localparam int TB  = 4;
  localparam int TS  = 2;
  localparam int BC  = 40;

  logic       clk;
  logic       reset_n;
  logic [7:0] ctrl;
  logic       silence_n;
  logic       buzzer;
  logic       ringing;
  logic       beat;

  int n_cmp = 0;
  int n_bad = 0;

  alarm_tone_gen #(
    .TONE_BASE  (TB),
    .TONE_STEP  (TS),
    .BEAT_CYCLES(BC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ctrl     (ctrl),
    .silence_n(silence_n),
    .buzzer   (buzzer),
    .ringing  (ringing),
    .beat     (beat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name,
                       input logic act,
                       input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b want %b",
               name, $time, act, exp);
    end
  endtask

  function automatic bit gate_of(input int m,
                                 input int b);
    case (m)
      0: return 1'b1;
      1: return (b % 2) == 0;
      2: return (b % 2) == 0 && b <= 4;
      default: return b < 4;
    endcase
  endfunction

  // Model: 0 idle, 1 ring, 2 silenced.
  // k = edges since ring entry; halves tracked
  // as a level plus cycles left in the half.
  int m_st = 0;
  int k, left, mode_b, bi;
  bit level;
  bit e_buz, e_ring, e_beat;

  always @(posedge clk) begin
    e_buz  = 1'b0;
    e_beat = 1'b0;
    if (!reset_n) begin
      m_st = 0;
    end else begin
      case (m_st)
        0: if (ctrl[0] && silence_n) begin
          m_st   = 1;
          k      = 0;
          level  = 1'b1;
          left   = TB + TS * int'(ctrl[7:3]);
          mode_b = int'(ctrl[2:1]);
        end
        1: if (!ctrl[0]) begin
          m_st = 0;
        end else if (!silence_n) begin
          m_st = 2;
        end else begin
          k++;
          bi    = ((k - 1) / BC) % 8;
          e_buz = level & gate_of(mode_b, bi);
          left--;
          if (left == 0) begin
            level = ~level;
            left  = TB + TS * int'(ctrl[7:3]);
          end
          if (k % BC == 0) begin
            e_beat = 1'b1;
            mode_b = int'(ctrl[2:1]);
          end
        end
        default: if (!ctrl[0]) m_st = 0;
      endcase
    end
    e_ring = (m_st == 1);
    #1;
    check("buzzer", buzzer, e_buz);
    check("ringing", ringing, e_ring);
    check("beat", beat, e_beat);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Checks buzzer over n edges, MSB of exp first.
  task automatic buz_seq(input string name,
                         input int n,
                         input logic [31:0] exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, buzzer, exp[n-1-i]);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    ctrl      = 8'hFF;
    silence_n = 1'b1;
    cyc(3);
    check("rst_ring", ringing, 1'b0);
    check("rst_buz", buzzer, 1'b0);
    check("rst_beat", beat, 1'b0);
    reset_n = 1'b1;
    cyc(1);
    check("rel_ring", ringing, 1'b1);
    check("rel_buz0", buzzer, 1'b0);
    cyc(1);
    check("rel_buz1", buzzer, 1'b1);

    // tone 0, continuous
    ctrl = 8'h00;
    cyc(1);
    check("idle_ring", ringing, 1'b0);
    ctrl = 8'h01;
    cyc(1);
    buz_seq("t0_seq", 9, 32'b111100001);
    cyc(30);
    check("beat_pre", beat, 1'b0);
    cyc(1);
    check("beat40", beat, 1'b1);
    cyc(1);
    check("beat41", beat, 1'b0);
    cyc(80);

    // tone 3 then tone 0 mid half
    ctrl = 8'h00;
    cyc(1);
    ctrl = 8'h19;
    cyc(1);
    buz_seq("t3_a", 3, 32'b111);
    ctrl = 8'h01;
    buz_seq("t3_b", 15,
            32'b111111100001111);
    cyc(20);

    // mode 2 triple beep
    ctrl = 8'h00;
    cyc(1);
    ctrl = 8'h05;
    cyc(1);
    cyc(45);
    check("m2_b1", buzzer, 1'b0);
    cyc(36);
    check("m2_b2", buzzer, 1'b1);
    cyc(89);
    check("m2_b4", buzzer, 1'b1);
    cyc(35);
    check("m2_b5", buzzer, 1'b0);
    cyc(450);

    // silence button
    silence_n = 1'b0;
    cyc(1);
    check("sil_ring", ringing, 1'b0);
    check("sil_buz", buzzer, 1'b0);
    silence_n = 1'b1;
    cyc(12);
    check("sil_hold", ringing, 1'b0);
    ctrl = 8'h00;
    cyc(1);
    ctrl = 8'h01;
    cyc(1);
    check("re_ring", ringing, 1'b1);
    buz_seq("re_seq", 5, 32'b11110);
    cyc(7);

    // disable and silence together
    ctrl      = 8'h00;
    silence_n = 1'b0;
    cyc(1);
    ctrl      = 8'h01;
    silence_n = 1'b1;
    cyc(1);
    check("both_ring", ringing, 1'b1);
    cyc(6);

    // reset mid-tone
    reset_n = 1'b0;
    cyc(1);
    check("mr_ring", ringing, 1'b0);
    check("mr_buz", buzzer, 1'b0);
    reset_n = 1'b1;
    cyc(1);
    buz_seq("mr_seq", 8, 32'b11110000);
    cyc(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
